// File: rtl/execute_stage_if.sv
// Signal bundle between the ID/EX register, hazard unit and the execute stage.
interface execute_stage_if;
    logic        EnableM;
    logic        FlushM;
    logic        RegWriteE;
    logic        MemtoRegE;
    logic        MemWriteE;
    logic        LoadE;
    logic        StopE;
    logic [3:0]  ALUControlE;
    logic [1:0]  ALUSrcAE;
    logic [1:0]  ALUSrcBE;
    logic [1:0]  RegDstE;
    logic [1:0]  HiLoSelE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] SignImmE;
    logic [31:0] SAE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RtE;
    logic [4:0]  RdE;
    logic [4:0]  WriteRegE;
    logic        StallE;
    logic        RegWriteM;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic        LoadM;
    logic        StopM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [4:0]  WriteRegM;

    modport master (
        output EnableM, FlushM, RegWriteE, MemtoRegE, MemWriteE, LoadE, StopE,
               ALUControlE, ALUSrcAE, ALUSrcBE, RegDstE, HiLoSelE,
               RD1E, RD2E, SignImmE, SAE, PCPlus4E, RtE, RdE,
        input  WriteRegE, StallE, RegWriteM, MemtoRegM, MemWriteM, LoadM, StopM,
               ALUOutM, WriteDataM, WriteRegM
    );

    modport slave (
        input  EnableM, FlushM, RegWriteE, MemtoRegE, MemWriteE, LoadE, StopE,
               ALUControlE, ALUSrcAE, ALUSrcBE, RegDstE, HiLoSelE,
               RD1E, RD2E, SignImmE, SAE, PCPlus4E, RtE, RdE,
        output WriteRegE, StallE, RegWriteM, MemtoRegM, MemWriteM, LoadM, StopM,
               ALUOutM, WriteDataM, WriteRegM
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS32 execute stage: operand muxes, ALU, HI/LO with iterative mul/div, EX/MEM register.
// Define MULDIV_EN to build HI/LO and the 32-cycle multiply/divide unit.
module execute_stage (
    input  logic           CLK,
    input  logic           RstN,
    execute_stage_if.slave bus
);
    logic [31:0] w_srcA, w_srcB, w_aluResult, w_result, w_hi, w_lo;
    logic [4:0]  w_writeReg;
    logic        w_stall;

    logic        r_regWrite, r_memtoReg, r_memWrite, r_load, r_stop;
    logic [31:0] r_aluOut, r_writeData;
    logic [4:0]  r_writeReg;

    always_comb begin
        case (bus.ALUSrcAE)
            2'b00:   w_srcA = bus.RD1E;
            2'b01:   w_srcA = bus.SAE;
            2'b10:   w_srcA = bus.PCPlus4E;
            default: w_srcA = 32'd0;
        endcase
        case (bus.ALUSrcBE)
            2'b00:   w_srcB = bus.RD2E;
            2'b01:   w_srcB = bus.SignImmE;
            default: w_srcB = 32'd0;
        endcase
        case (bus.RegDstE)
            2'b00:   w_writeReg = bus.RtE;
            2'b01:   w_writeReg = bus.RdE;
            default: w_writeReg = 5'd31;
        endcase
    end

    // Mul/div opcodes fall to the default and produce 0 on the ALU path.
    always_comb begin
        w_aluResult = 32'd0;
        case (bus.ALUControlE)
            4'b0000: w_aluResult = w_srcA + w_srcB;
            4'b0001: w_aluResult = w_srcA - w_srcB;
            4'b0010: w_aluResult = w_srcA & w_srcB;
            4'b0011: w_aluResult = w_srcA | w_srcB;
            4'b0100: w_aluResult = w_srcA ^ w_srcB;
            4'b0101: w_aluResult = ~(w_srcA | w_srcB);
            4'b0110: w_aluResult = {31'd0, $signed(w_srcA) < $signed(w_srcB)};
            4'b0111: w_aluResult = {31'd0, w_srcA < w_srcB};
            4'b1000: w_aluResult = w_srcB << w_srcA[4:0];
            4'b1001: w_aluResult = w_srcB >> w_srcA[4:0];
            4'b1010: w_aluResult = $signed(w_srcB) >>> w_srcA[4:0];
            4'b1011: w_aluResult = {w_srcB[15:0], 16'd0};
            default: w_aluResult = 32'd0;
        endcase
    end

`ifdef MULDIV_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} mdState_t;
    mdState_t    r_state, w_nextState;
    logic [31:0] r_hi, r_lo, r_accHi, r_accLo, r_opB, r_dividend;
    logic [4:0]  r_count;
    logic        r_isDiv, r_negA, r_negB;
    logic        w_mdOp, w_start, w_lastStep, w_aNeg, w_bNeg;
    logic [32:0] w_mulSum, w_divRem, w_divDiff;
    logic [31:0] w_stepHi, w_stepLo, w_finHi, w_finLo;
    logic [63:0] w_prod;

    assign w_mdOp = (bus.ALUControlE[3:2] == 2'b11) && !bus.RegWriteE;
    assign w_aNeg = !bus.ALUControlE[0] && w_srcA[31];
    assign w_bNeg = !bus.ALUControlE[0] && w_srcB[31];

    // DONE returns to IDLE without looking at the op, so a held instruction cannot restart.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_lastStep  = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: if (w_mdOp) begin
                w_nextState = RUN;
                w_start     = 1'b1;
                w_stall     = 1'b1;
            end
            RUN: begin
                w_stall = 1'b1;
                if (r_count == 5'd31) begin
                    w_nextState = DONE;
                    w_lastStep  = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Shared accumulator: {accHi,accLo} is product (shift-add) or remainder:quotient (restoring).
    always_comb begin
        w_mulSum  = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opB} : 33'd0);
        w_divRem  = {r_accHi, r_accLo[31]};
        w_divDiff = w_divRem - {1'b0, r_opB};
        if (!r_isDiv) begin
            w_stepHi = w_mulSum[32:1];
            w_stepLo = {w_mulSum[0], r_accLo[31:1]};
        end else if (!w_divDiff[32]) begin
            w_stepHi = w_divDiff[31:0];
            w_stepLo = {r_accLo[30:0], 1'b1};
        end else begin
            w_stepHi = w_divRem[31:0];
            w_stepLo = {r_accLo[30:0], 1'b0};
        end
        w_prod = (r_negA ^ r_negB) ? -{w_stepHi, w_stepLo} : {w_stepHi, w_stepLo};
        if (!r_isDiv) begin
            w_finHi = w_prod[63:32];
            w_finLo = w_prod[31:0];
        end else if (r_opB == 32'd0) begin
            w_finHi = r_dividend;
            w_finLo = 32'hFFFF_FFFF;
        end else begin
            w_finHi = r_negA ? -w_stepHi : w_stepHi;
            w_finLo = (r_negA ^ r_negB) ? -w_stepLo : w_stepLo;
        end
    end

    always_ff @(posedge CLK or negedge RstN) begin
        if (!RstN) begin
            r_state    <= IDLE;
            r_count    <= 5'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_accHi    <= 32'd0;
            r_accLo    <= 32'd0;
            r_opB      <= 32'd0;
            r_dividend <= 32'd0;
            r_isDiv    <= 1'b0;
            r_negA     <= 1'b0;
            r_negB     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_start) begin
                r_count    <= 5'd0;
                r_isDiv    <= bus.ALUControlE[1];
                r_negA     <= w_aNeg;
                r_negB     <= w_bNeg;
                r_accHi    <= 32'd0;
                r_accLo    <= w_aNeg ? -w_srcA : w_srcA;
                r_opB      <= w_bNeg ? -w_srcB : w_srcB;
                r_dividend <= w_srcA;
            end else if (r_state == RUN) begin
                r_count <= r_count + 5'd1;
                r_accHi <= w_stepHi;
                r_accLo <= w_stepLo;
                if (w_lastStep) begin
                    r_hi <= w_finHi;
                    r_lo <= w_finLo;
                end
            end
        end
    end

    assign w_hi = r_hi;
    assign w_lo = r_lo;
`else
    assign w_hi    = 32'd0;
    assign w_lo    = 32'd0;
    assign w_stall = 1'b0;
`endif

    always_comb begin
        case (bus.HiLoSelE)
            2'b01:   w_result = w_hi;
            2'b10:   w_result = w_lo;
            default: w_result = w_aluResult;
        endcase
    end

    // A stalled mul/div must not leak into MEM, so the stall inserts a bubble; StopM still follows StopE.
    always_ff @(posedge CLK or negedge RstN) begin
        if (!RstN) begin
            r_regWrite  <= 1'b0;
            r_memtoReg  <= 1'b0;
            r_memWrite  <= 1'b0;
            r_load      <= 1'b0;
            r_stop      <= 1'b0;
            r_aluOut    <= 32'd0;
            r_writeData <= 32'd0;
            r_writeReg  <= 5'd0;
        end else if (bus.FlushM || (w_stall && bus.EnableM)) begin
            r_regWrite  <= 1'b0;
            r_memtoReg  <= 1'b0;
            r_memWrite  <= 1'b0;
            r_load      <= 1'b0;
            r_stop      <= bus.StopE;
            r_aluOut    <= 32'd0;
            r_writeData <= 32'd0;
            r_writeReg  <= 5'd0;
        end else if (bus.EnableM) begin
            r_regWrite  <= bus.RegWriteE;
            r_memtoReg  <= bus.MemtoRegE;
            r_memWrite  <= bus.MemWriteE;
            r_load      <= bus.LoadE;
            r_stop      <= bus.StopE;
            r_aluOut    <= w_result;
            r_writeData <= bus.RD2E;
            r_writeReg  <= w_writeReg;
        end
    end

    assign bus.WriteRegE  = w_writeReg;
    assign bus.StallE     = w_stall;
    assign bus.RegWriteM  = r_regWrite;
    assign bus.MemtoRegM  = r_memtoReg;
    assign bus.MemWriteM  = r_memWrite;
    assign bus.LoadM      = r_load;
    assign bus.StopM      = r_stop;
    assign bus.ALUOutM    = r_aluOut;
    assign bus.WriteDataM = r_writeData;
    assign bus.WriteRegM  = r_writeReg;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus random traffic against a behavioural model.
// The model follows MULDIV_EN so the same bench serves both builds.
module tb_execute_stage;
    logic CLK = 1'b0;
    logic RstN;
    int   checks = 0;
    int   failures = 0;

    execute_stage_if bus ();
    execute_stage dut (.CLK(CLK), .RstN(RstN), .bus(bus));

    always #5 CLK = ~CLK;

    // Reference state: architectural HI/LO, cycles since a mul/div started, expected EX/MEM contents.
    logic [31:0] mHi = 32'd0, mLo = 32'd0, pendHi = 32'd0, pendLo = 32'd0;
    int          mdPhase = 0;
    logic        eRegWrite = 1'b0, eMemtoReg = 1'b0, eMemWrite = 1'b0, eLoad = 1'b0, eStop = 1'b0;
    logic [31:0] eAluOut = 32'd0, eWriteData = 32'd0;
    logic [4:0]  eWriteReg = 5'd0;
    logic        obsStall = 1'b0, lastStallExp = 1'b0;
    int          stallCount;

`ifdef MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        int sb = b;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return b << a[4:0];
            4'd9:    return b >> a[4:0];
            4'd10:   return 32'(sb >>> a[4:0]);
            4'd11:   return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    task automatic mulDivModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] hi, output logic [31:0] lo);
        int          sa = a;
        int          sb = b;
        longint      sp;
        logic [63:0] up;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            4'd12: begin sp = longint'(sa) * longint'(sb); {hi, lo} = 64'(sp); end
            4'd13: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
            4'd14: begin
                if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 32'd0; end
                else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
            end
            default: begin
                if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    task automatic tickAndCheck();
        logic [31:0] a, b, res;
        logic [4:0]  wr;
        logic        isMd, stallExp;
        #1;
        a = (bus.ALUSrcAE == 2'd0) ? bus.RD1E : (bus.ALUSrcAE == 2'd1) ? bus.SAE :
            (bus.ALUSrcAE == 2'd2) ? bus.PCPlus4E : 32'd0;
        b = (bus.ALUSrcBE == 2'd0) ? bus.RD2E : (bus.ALUSrcBE == 2'd1) ? bus.SignImmE : 32'd0;
        wr = (bus.RegDstE == 2'd0) ? bus.RtE : (bus.RegDstE == 2'd1) ? bus.RdE : 5'd31;
        isMd = MD && (bus.ALUControlE >= 4'd12) && !bus.RegWriteE;
        stallExp = (mdPhase == 0 && isMd) || (mdPhase >= 1 && mdPhase <= 32);
        checkOutput("WriteRegE", {27'd0, bus.WriteRegE}, {27'd0, wr});
        checkOutput("StallE", {31'd0, bus.StallE}, {31'd0, stallExp});
        obsStall = bus.StallE;
        lastStallExp = stallExp;
        res = (bus.HiLoSelE == 2'd1) ? mHi : (bus.HiLoSelE == 2'd2) ? mLo : aluModel(bus.ALUControlE, a, b);
        if (bus.FlushM || (stallExp && bus.EnableM)) begin
            {eRegWrite, eMemtoReg, eMemWrite, eLoad} = 4'd0;
            eStop = bus.StopE;
            eAluOut = 32'd0; eWriteData = 32'd0; eWriteReg = 5'd0;
        end else if (bus.EnableM) begin
            eRegWrite = bus.RegWriteE; eMemtoReg = bus.MemtoRegE; eMemWrite = bus.MemWriteE;
            eLoad = bus.LoadE; eStop = bus.StopE;
            eAluOut = res; eWriteData = bus.RD2E; eWriteReg = wr;
        end
        if (mdPhase == 0 && isMd) begin
            mulDivModel(bus.ALUControlE, a, b, pendHi, pendLo);
            mdPhase = 1;
        end else if (mdPhase >= 1 && mdPhase < 32) mdPhase++;
        else if (mdPhase == 32) begin mdPhase = 33; mHi = pendHi; mLo = pendLo; end
        else if (mdPhase == 33) mdPhase = 0;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("RegWriteM", {31'd0, bus.RegWriteM}, {31'd0, eRegWrite});
        checkOutput("MemtoRegM", {31'd0, bus.MemtoRegM}, {31'd0, eMemtoReg});
        checkOutput("MemWriteM", {31'd0, bus.MemWriteM}, {31'd0, eMemWrite});
        checkOutput("LoadM", {31'd0, bus.LoadM}, {31'd0, eLoad});
        checkOutput("StopM", {31'd0, bus.StopM}, {31'd0, eStop});
        checkOutput("ALUOutM", bus.ALUOutM, eAluOut);
        checkOutput("WriteDataM", bus.WriteDataM, eWriteData);
        checkOutput("WriteRegM", {27'd0, bus.WriteRegM}, {27'd0, eWriteReg});
    endtask

    task automatic clearInputs();
        bus.EnableM = 1'b1; bus.FlushM = 1'b0;
        bus.RegWriteE = 1'b0; bus.MemtoRegE = 1'b0; bus.MemWriteE = 1'b0; bus.LoadE = 1'b0; bus.StopE = 1'b0;
        bus.ALUControlE = 4'd0; bus.ALUSrcAE = 2'd0; bus.ALUSrcBE = 2'd0; bus.RegDstE = 2'd0; bus.HiLoSelE = 2'd0;
        bus.RD1E = 32'd0; bus.RD2E = 32'd0; bus.SignImmE = 32'd0; bus.SAE = 32'd0; bus.PCPlus4E = 32'd0;
        bus.RtE = 5'd0; bus.RdE = 5'd0;
    endtask

    task automatic setInstr(input logic [3:0] op, input logic [1:0] aSel, input logic [1:0] bSel,
                            input logic [1:0] hiLo, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic regWrite);
        clearInputs();
        bus.ALUControlE = op; bus.ALUSrcAE = aSel; bus.ALUSrcBE = bSel; bus.HiLoSelE = hiLo;
        bus.RD1E = rd1; bus.RD2E = rd2; bus.RegWriteE = regWrite;
    endtask

    task automatic runMulDiv();
        stallCount = 0;
        for (int c = 0; c < 40; c++) begin
            tickAndCheck();
            if (obsStall) stallCount++;
            else break;
        end
    endtask

    function automatic logic [31:0] randWord();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom();
    endfunction

    task automatic applyStimulus();
        bus.EnableM = ($urandom_range(0, 7) != 0);
        bus.FlushM  = ($urandom_range(0, 7) == 0);
        if (lastStallExp) return;
        bus.ALUControlE = ($urandom_range(0, 11) == 0) ? 4'(12 + $urandom_range(0, 3)) : 4'($urandom_range(0, 11));
        bus.RegWriteE = (bus.ALUControlE >= 4'd12) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
        bus.MemtoRegE = 1'($urandom_range(0, 1)); bus.MemWriteE = 1'($urandom_range(0, 1));
        bus.LoadE = 1'($urandom_range(0, 1)); bus.StopE = ($urandom_range(0, 15) == 0);
        bus.ALUSrcAE = 2'($urandom_range(0, 3)); bus.ALUSrcBE = 2'($urandom_range(0, 3));
        bus.RegDstE = 2'($urandom_range(0, 3));
        bus.HiLoSelE = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        bus.RD1E = randWord(); bus.RD2E = randWord(); bus.SignImmE = randWord();
        bus.SAE = 32'($urandom_range(0, 40)); bus.PCPlus4E = $urandom();
        bus.RtE = 5'($urandom()); bus.RdE = 5'($urandom());
    endtask

    initial begin
        RstN = 1'b0;
        clearInputs();
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("reset_StallE", {31'd0, bus.StallE}, 32'd0);
        checkOutput("reset_ALUOutM", bus.ALUOutM, 32'd0);
        checkOutput("reset_RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);
        RstN = 1'b1;

        setInstr(4'd0, 2'd0, 2'd1, 2'd0, 32'd5, 32'd0, 1'b1);
        bus.SignImmE = 32'hFFFF_FFFF; bus.RtE = 5'd8;
        tickAndCheck();
        checkOutput("add_ALUOutM", bus.ALUOutM, 32'd4);
        checkOutput("add_WriteRegM", {27'd0, bus.WriteRegM}, 32'd8);

        setInstr(4'd10, 2'd1, 2'd0, 2'd0, 32'd0, 32'h8000_0000, 1'b1);
        bus.SAE = 32'd4;
        tickAndCheck();
        checkOutput("sra", bus.ALUOutM, 32'hF800_0000);
        setInstr(4'd6, 2'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        tickAndCheck();
        checkOutput("slt", bus.ALUOutM, 32'd1);
        setInstr(4'd7, 2'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        tickAndCheck();
        checkOutput("sltu", bus.ALUOutM, 32'd0);

        setInstr(4'd12, 2'd0, 2'd0, 2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        runMulDiv();
        checkOutput("mult_stall_len", 32'(stallCount), MD ? 32'd33 : 32'd0);
        setInstr(4'd0, 2'd0, 2'd0, 2'd2, 32'd1, 32'd1, 1'b1);
        tickAndCheck();
        checkOutput("mult_lo", bus.ALUOutM, MD ? 32'hFFFF_FFEB : 32'd0);
        setInstr(4'd0, 2'd0, 2'd0, 2'd1, 32'd1, 32'd1, 1'b1);
        tickAndCheck();
        checkOutput("mult_hi", bus.ALUOutM, MD ? 32'hFFFF_FFFF : 32'd0);

        setInstr(4'd14, 2'd0, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        runMulDiv();
        setInstr(4'd0, 2'd0, 2'd0, 2'd2, 32'd0, 32'd0, 1'b1);
        tickAndCheck();
        checkOutput("div_lo", bus.ALUOutM, MD ? 32'hFFFF_FFFD : 32'd0);
        setInstr(4'd0, 2'd0, 2'd0, 2'd1, 32'd0, 32'd0, 1'b1);
        tickAndCheck();
        checkOutput("div_hi", bus.ALUOutM, MD ? 32'hFFFF_FFFF : 32'd0);

        setInstr(4'd15, 2'd0, 2'd0, 2'd0, 32'd9, 32'd0, 1'b0);
        runMulDiv();
        setInstr(4'd0, 2'd0, 2'd0, 2'd2, 32'd0, 32'd0, 1'b1);
        tickAndCheck();
        checkOutput("divu0_lo", bus.ALUOutM, MD ? 32'hFFFF_FFFF : 32'd0);
        setInstr(4'd0, 2'd0, 2'd0, 2'd1, 32'd0, 32'd0, 1'b1);
        tickAndCheck();
        checkOutput("divu0_hi", bus.ALUOutM, MD ? 32'd9 : 32'd0);

        setInstr(4'd0, 2'd0, 2'd0, 2'd0, 32'd3, 32'd4, 1'b1);
        bus.MemWriteE = 1'b1; bus.FlushM = 1'b1; bus.EnableM = 1'b0;
        tickAndCheck();
        checkOutput("flush_RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);
        checkOutput("flush_MemWriteM", {31'd0, bus.MemWriteM}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            tickAndCheck();
        end
        while (lastStallExp) begin
            applyStimulus();
            tickAndCheck();
        end
        clearInputs();
        tickAndCheck();

        setInstr(4'd0, 2'd0, 2'd0, 2'd0, 32'd20, 32'd22, 1'b1);
        tickAndCheck();
        setInstr(4'd13, 2'd0, 2'd0, 2'd0, 32'h1234_5678, 32'h0000_0100, 1'b0);
        bus.EnableM = 1'b0;
        for (int c = 0; c < 11; c++) tickAndCheck();
        #2 RstN = 1'b0;
        #1;
        checkOutput("rst_mid_StallE", {31'd0, bus.StallE}, 32'd0);
        checkOutput("rst_mid_ALUOutM", bus.ALUOutM, 32'd0);
        checkOutput("rst_mid_RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);
        checkOutput("rst_mid_WriteDataM", bus.WriteDataM, 32'd0);
        {eRegWrite, eMemtoReg, eMemWrite, eLoad, eStop} = 5'd0;
        eAluOut = 32'd0; eWriteData = 32'd0; eWriteReg = 5'd0;
        mHi = 32'd0; mLo = 32'd0; mdPhase = 0; lastStallExp = 1'b0;
        @(negedge CLK);
        RstN = 1'b1;
        setInstr(4'd0, 2'd0, 2'd0, 2'd1, 32'd0, 32'd0, 1'b1);
        tickAndCheck();
        checkOutput("rst_hi", bus.ALUOutM, 32'd0);
        setInstr(4'd0, 2'd0, 2'd0, 2'd2, 32'd0, 32'd0, 1'b1);
        tickAndCheck();
        checkOutput("rst_lo", bus.ALUOutM, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
